// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned word for the decoder and handles redirects/exceptions.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] disc_addr_q, disc_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        addr_err_q, addr_err_d;

  logic        take;
  logic        misalign;
  logic [31:0] target;
  logic        buf_free;

  always_comb begin
    take     = exc | redirect;
    misalign = redirect & ~exc & (redirect_pc[1:0] != 2'b00);
    target   = (exc | misalign) ? EXC_PC : redirect_pc;
    buf_free = ~if_valid_q | if_ready;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    addr_err_d  = 1'b0;

    if (if_valid_q && if_ready) begin
      if_valid_d = 1'b0;
    end

    if (take) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      addr_err_d = misalign;
      unique case (state_q)
        REQ: begin
          // Unacked request must still complete on the bus; remember its address.
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end
        end
        DISCARD: state_d = imem_ack ? IDLE : DISCARD;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (buf_free) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            // Decoder accepting this cycle lets the next word follow directly.
            state_d    = if_ready ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign addr_err  = addr_err_q;

endmodule
